// File: rtl/spike_ev_if.sv
// Event stream from the spike collector to the host/recorder.
// The collector drives the master side and the host drives the slave side.
interface spike_ev_if #(
  parameter int unsigned TsWidth = 16
) ();
  logic               valid;
  logic               ready;
  logic [7:0]         col;
  logic               on_off;
  logic [TsWidth-1:0] timestamp;

  modport master (output valid, col, on_off, timestamp, input ready);
  modport slave  (input valid, col, on_off, timestamp, output ready);
endinterface

// File: rtl/spike_event_collector.sv
// Collects spikes from every neuron column, timestamps them, and streams them to the host.
// Each column has one pending slot, a round-robin arbiter feeds a first-word-fall-through FIFO.
module spike_event_collector #(
  parameter int unsigned NumCols   = 1,
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned TsWidth   = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [NumCols-1:0]         col_valid_i,
  input  logic [NumCols-1:0]         col_on_off_i,
  spike_ev_if.master                 ev,
  output logic [$clog2(FifoDepth):0] fifo_level_o,
  output logic [15:0]                drop_count_o
);

  localparam int unsigned ColW  = (NumCols > 1) ? $clog2(NumCols) : 1;
  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam int unsigned LvlW  = AddrW + 1;

  typedef struct packed {
    logic [7:0]         col;
    logic               on_off;
    logic [TsWidth-1:0] ts;
  } ev_t;

  logic [TsWidth-1:0] ts_q, ts_d;
  logic [NumCols-1:0] occ_q, occ_d;
  logic [NumCols-1:0] son_q, son_d;
  logic [TsWidth-1:0] sts_q [NumCols];
  logic [TsWidth-1:0] sts_d [NumCols];
  logic [ColW-1:0]    ptr_q, ptr_d;
  logic [AddrW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LvlW-1:0]    lvl_q, lvl_d;
  logic [15:0]        drop_q, drop_d;
  ev_t                mem_q [FifoDepth];

  logic            pop, push, can_grant, gnt_any;
  logic [ColW-1:0] gnt_idx;
  ev_t             push_data, head;

  assign pop       = (lvl_q != '0) & ev.ready;
  // A full FIFO can still take a grant when the head leaves at the same edge.
  assign can_grant = (lvl_q != LvlW'(FifoDepth)) | pop;
  assign push      = gnt_any & can_grant;

  // Round-robin search over occupied slots, starting at the pointer.
  always_comb begin
    int unsigned c;
    c       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NumCols; i++) begin
      c = (32'(ptr_q) + i) % NumCols;
      if (!gnt_any && occ_q[c]) begin
        gnt_any = 1'b1;
        gnt_idx = ColW'(c);
      end
    end
  end

  always_comb begin
    push_data        = '0;
    push_data.col    = 8'(gnt_idx);
    push_data.on_off = son_q[gnt_idx];
    push_data.ts     = sts_q[gnt_idx];
  end

  always_comb begin
    int unsigned ndrop;
    int unsigned dsum;
    ndrop = 0;
    dsum  = 0;
    occ_d = occ_q;
    son_d = son_q;
    sts_d = sts_q;
    ptr_d = ptr_q;
    if (push) begin
      occ_d[gnt_idx] = 1'b0;
      ptr_d          = ColW'((32'(gnt_idx) + 1) % NumCols);
    end
    // A slot freed by this cycle's grant can take a new spike without a drop.
    if (enable_i) begin
      for (int unsigned c = 0; c < NumCols; c++) begin
        if (col_valid_i[c]) begin
          if (occ_d[c]) begin
            ndrop++;
          end else begin
            occ_d[c] = 1'b1;
            son_d[c] = col_on_off_i[c];
            sts_d[c] = ts_q;
          end
        end
      end
    end
    dsum   = 32'(drop_q) + ndrop;
    drop_d = (dsum > 32'hFFFF) ? 16'hFFFF : dsum[15:0];
    ts_d   = enable_i ? ts_q + 1'b1 : ts_q;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    lvl_d  = lvl_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_q   <= '0;
      occ_q  <= '0;
      son_q  <= '0;
      ptr_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      drop_q <= '0;
      for (int unsigned c = 0; c < NumCols; c++) sts_q[c] <= '0;
    end else if (clear_i) begin
      ts_q   <= '0;
      occ_q  <= '0;
      son_q  <= '0;
      ptr_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      drop_q <= '0;
      for (int unsigned c = 0; c < NumCols; c++) sts_q[c] <= '0;
    end else begin
      ts_q   <= ts_d;
      occ_q  <= occ_d;
      son_q  <= son_d;
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      drop_q <= drop_d;
      for (int unsigned c = 0; c < NumCols; c++) sts_q[c] <= sts_d[c];
    end
  end

  // Storage needs no reset: the level counter alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign head = mem_q[rd_q];

  always_comb begin
    ev.valid     = (lvl_q != '0);
    ev.col       = ev.valid ? head.col : 8'h00;
    ev.on_off    = ev.valid ? head.on_off : 1'b0;
    ev.timestamp = ev.valid ? head.ts : '0;
  end

  assign fifo_level_o = lvl_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_spike_event_collector.sv
// Bench for spike_event_collector: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based model of the collector.
module tb_spike_event_collector;
  localparam int unsigned NC = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n, enable, clear, ready;
  logic [NC-1:0] cv, co;
  logic [4:0]    level;
  logic [15:0]   drops;

  always #5 clk = ~clk;

  spike_ev_if #(.TsWidth(TW)) ev_if ();
  assign ev_if.ready = ready;

  spike_event_collector #(.NumCols(NC), .FifoDepth(D), .TsWidth(TW)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .enable_i     (enable),
    .clear_i      (clear),
    .col_valid_i  (cv),
    .col_on_off_i (co),
    .ev           (ev_if),
    .fifo_level_o (level),
    .drop_count_o (drops)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: pending spikes per column, an event queue, counters.
  typedef struct {int col; int on; int ts;} mev_t;
  mev_t mq[$];
  bit   mocc[NC];
  int   mon[NC];
  int   mts[NC];
  int   mptr, mts_cnt, mdrop;

  function automatic void mreset();
    mq.delete();
    for (int c = 0; c < NC; c++) begin
      mocc[c] = 0;
      mon[c]  = 0;
      mts[c]  = 0;
    end
    mptr = 0;
    mts_cnt = 0;
    mdrop = 0;
  endfunction

  function automatic void mstep();
    int g;
    bit pop;
    if (clear) begin
      mreset();
      return;
    end
    pop = (mq.size() > 0) && ready;
    g = -1;
    if (mq.size() < D || pop) begin
      for (int i = 0; i < NC; i++) begin
        int c = (mptr + i) % NC;
        if (g < 0 && mocc[c]) g = c;
      end
    end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{g, mon[g], mts[g]});
      mocc[g] = 0;
      mptr = (g + 1) % NC;
    end
    if (enable) begin
      for (int c = 0; c < NC; c++) begin
        if (cv[c]) begin
          if (mocc[c]) begin
            if (mdrop < 65535) mdrop++;
          end else begin
            mocc[c] = 1;
            mon[c]  = co[c];
            mts[c]  = mts_cnt;
          end
        end
      end
      mts_cnt = (mts_cnt + 1) % (1 << TW);
    end
  endfunction

  // Compare on the falling edge, then advance the model by the coming rising edge.
  always @(negedge clk) begin
    bit ok;
    int hc, ho, ht;
    if (!rst_n) mreset();
    hc = 0; ho = 0; ht = 0;
    if (mq.size() > 0) begin
      hc = mq[0].col; ho = mq[0].on; ht = mq[0].ts;
    end
    ok = (ev_if.valid == (mq.size() > 0)) && (int'(level) == mq.size()) &&
         (int'(drops) == mdrop);
    if (mq.size() > 0)
      ok = ok && (int'(ev_if.col) == hc) && (int'(ev_if.on_off) == ho) &&
           (int'(ev_if.timestamp) == ht);
    checks++;
    if (ok) passed++;
    else $display("FAIL model_cmp t=%0t: got v=%0b lvl=%0d drop=%0d col=%0d on=%0d ts=%0d, expected v=%0b lvl=%0d drop=%0d col=%0d on=%0d ts=%0d",
                  $time, ev_if.valid, level, drops, ev_if.col, ev_if.on_off, ev_if.timestamp,
                  mq.size() > 0, mq.size(), mdrop, hc, ho, ht);
    if (rst_n) mstep();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ready = 1'b1; cv = '0; co = '0;
    tick(); tick();
    check("reset_valid", ev_if.valid, 0);
    check("reset_level", level, 0);
    check("reset_drops", drops, 0);
    rst_n = 1'b1;
    tick();

    // Single spike on col 2 at ts=5, visible two cycles after the strobe.
    clear = 1'b1; enable = 1'b1; tick(); clear = 1'b0;
    repeat (5) tick();
    cv = 4'b0100; co = 4'b0100; tick(); cv = '0; co = '0;
    check("t1_not_yet", ev_if.valid, 0);
    tick();
    check("t1_valid", ev_if.valid, 1);
    check("t1_col", ev_if.col, 2);
    check("t1_on", ev_if.on_off, 1);
    check("t1_ts", ev_if.timestamp, 5);
    tick();
    check("t1_popped", ev_if.valid, 0);

    // All columns in one cycle at ts=10: ordered 0..3.
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (10) tick();
    cv = 4'hF; co = 4'b1010; tick(); cv = '0;
    tick();
    for (int i = 0; i < NC; i++) begin
      check("t2_col", ev_if.col, i);
      check("t2_on", ev_if.on_off, (i % 2));
      check("t2_ts", ev_if.timestamp, 10);
      tick();
    end
    check("t2_drops", drops, 0);
    check("t2_empty", ev_if.valid, 0);

    // Timestamp wrap with same-cycle grant and refire on col 0.
    co = '0;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (15) tick();
    cv = 4'b0001; co = 4'b0001; tick(); co = '0; tick(); cv = '0;
    check("t5_ts15", ev_if.timestamp, 15);
    check("t5_on1", ev_if.on_off, 1);
    tick();
    check("t5_ts0", ev_if.timestamp, 0);
    check("t5_on0", ev_if.on_off, 0);
    check("t5_drops", drops, 0);

    // Backpressure: fill the FIFO, keep a slot pending, then lose spikes.
    ready = 1'b0; co = 4'hF;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cv = 4'(1 << (i % 4));
      tick();
    end
    cv = 4'b0010; tick(); tick(); cv = '0;
    check("t4_drop1", drops, 1);
    cv = 4'b0001; tick(); cv = '0;
    check("t3_drops", drops, 2);
    check("t3_level", level, 16);
    check("t3_model_lvl", mq.size(), 16);
    check("t3_head_col", ev_if.col, 0);
    check("t3_head_ts", ev_if.timestamp, 0);
    repeat (3) tick();
    check("t3_stable_col", ev_if.col, 0);
    check("t3_stable_ts", ev_if.timestamp, 0);
    ready = 1'b1;
    repeat (25) tick();
    check("t3_drained", level, 0);

    // Asynchronous reset mid-stream with 7 queued events and a slot pending.
    ready = 1'b0;
    cv = 4'hF; tick(); cv = '0; repeat (3) tick();
    cv = 4'hF; tick(); cv = '0; repeat (3) tick();
    check("t6_level7", level, 7);
    check("t6_drops2", drops, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", ev_if.valid, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_drops", drops, 0);
    tick(); rst_n = 1'b1; tick();

    // Synchronous clear after building up events and drops.
    cv = 4'hF; tick(); tick(); cv = '0;
    repeat (5) tick();
    check("t6c_level", level, 5);
    check("t6c_drops", drops, 3);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t6c_valid", ev_if.valid, 0);
    check("t6c_level0", level, 0);
    check("t6c_drops0", drops, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 9) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      clear  = ($urandom_range(0, 299) == 0);
      cv     = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      co     = 4'($urandom);
      tick();
    end
    clear = 1'b0; cv = '0; enable = 1'b1;

    // Drop counter saturation: FIFO full, all slots held, every column firing.
    ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    cv = 4'hF;
    repeat (16420) tick();
    cv = '0;
    check("sat_drops", drops, 16'hFFFF);
    check("sat_level", level, 16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
